// File: rtl/fetch_stage_pkg.sv
// Shared constants for the fetch stage: reset PC, NOP encoding and the
// fetch FSM state encoding.
package fetch_stage_pkg;

  localparam logic [31:0] CPU_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] CPU_NOP      = 32'h0000_0000;
  localparam logic [31:0] WORD_MASK    = 32'hFFFF_FFFC;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

endpackage

// File: rtl/fetch_stage_fd_reg.sv
// F/D pipeline register: holds on hold_i, loads on en_i, otherwise
// inserts a NOP bubble while keeping the old PC.
module fetch_stage_fd_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = CPU_NOP
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        hold_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        valid_o
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (hold_i) begin
      pc_d    = pc_q;
    end else if (en_i) begin
      pc_d    = pc_i;
      instr_d = instr_i;
      valid_d = 1'b1;
    end else begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q    <= 32'h0;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign instr_o = instr_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: F_PC register, req/gnt/rvalid fetch FSM with a
// one-word hold buffer for stalls, and the F/D pipeline register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = CPU_RESET_PC,
  parameter logic [31:0] NOP_INSTR = CPU_NOP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc_in,
  input  logic        stall,
  output logic [31:0] F_PC,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] D_PC,
  output logic [31:0] D_Instr,
  output logic        D_valid,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a request transfers in a cycle with imem_req && imem_gnt;
  // its single rvalid beat comes in a later cycle and is accepted only
  // while that request is outstanding (S_WAIT), so stale beats are dropped.

  logic [1:0]  state_q, state_d;
  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] hold_q, hold_d;
  logic        out_q, out_d;
  logic        rvalid_ok;
  logic        deliver;
  logic [31:0] dlv_instr;
  logic [31:0] npc_word;

  assign npc_word  = npc_in & WORD_MASK;
  assign rvalid_ok = imem_rvalid && out_q && (state_q == S_WAIT);

  always_comb begin
    state_d   = state_q;
    f_pc_d    = f_pc_q;
    hold_d    = hold_q;
    out_d     = out_q;
    deliver   = 1'b0;
    dlv_instr = hold_q;
    imem_req  = 1'b0;
    imem_addr = f_pc_q & WORD_MASK;
    case (state_q)
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          state_d = S_WAIT;
          out_d   = 1'b1;
        end
      end
      S_WAIT: begin
        if (rvalid_ok) begin
          out_d = 1'b0;
          if (!stall) begin
            deliver   = 1'b1;
            dlv_instr = imem_rdata;
            f_pc_d    = npc_word;
            // Back-to-back request for the next PC in the delivery cycle.
            imem_req  = 1'b1;
            imem_addr = npc_word;
            if (imem_gnt) begin
              out_d = 1'b1;
            end else begin
              state_d = S_REQ;
            end
          end else begin
            hold_d  = imem_rdata;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          deliver = 1'b1;
          f_pc_d  = npc_word;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
    if (!reset) imem_req = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_REQ;
      f_pc_q  <= RESET_PC;
      hold_q  <= 32'h0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      f_pc_q  <= f_pc_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
    end
  end

  fetch_stage_fd_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_fd_reg (
    .clk_i   (clk),
    .rst_ni  (reset),
    .en_i    (deliver),
    .hold_i  (stall),
    .pc_i    (f_pc_q),
    .instr_i (dlv_instr),
    .pc_o    (D_PC),
    .instr_o (D_Instr),
    .valid_o (D_valid)
  );

  assign F_PC        = f_pc_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: owns the F-stage PC register and the F/D pipeline register.
- Issues requests to a variable-latency instruction memory over a req/gnt/rvalid handshake.
- Feeds F_PC to the next-PC block and loads that block's result (npc_in) as the new F_PC each time an instruction is handed to D.
- Handles hazard-unit stalls and memory wait states by holding D or inserting NOP bubbles.

Parameters:
- RESET_PC, 32'h0000_3000, F_PC value after reset.
- NOP_INSTR, 32'h0000_0000, instruction word placed in D on a bubble.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- npc_in  in  32  next PC from the next-PC block; bits [1:0] ignored.
- stall  in  1  hazard unit: D stage must hold its contents this cycle.
- F_PC  out  32  current fetch PC, to the next-PC block.
- imem_req  out  1  instruction-memory request valid.
- imem_addr  out  32  request word address, bits [1:0]=00.
- imem_gnt  in  1  memory accepted the request this cycle (meaningful only with imem_req).
- imem_rvalid  in  1  read data valid; exactly one per granted request, no earlier than the cycle after gnt.
- imem_rdata  in  32  instruction word.
- D_PC  out  32  PC of the instruction in D.
- D_Instr  out  32  instruction in D.
- D_valid  out  1  D holds a real instruction (0 = bubble).

Behaviour:
- All state updates on posedge clk.
- Reset is sampled only at posedge, when reset==0. Reset values:
  - F_PC=RESET_PC, D_PC=0, D_Instr=NOP_INSTR, D_valid=0.
  - Hold buffer = 0, state=S_REQ.
  - imem_req=0 while reset is low.
- Reset wins over every other event, including a reset asserted mid-transaction. Any rvalid arriving after reset for a request granted before reset is discarded: track an outstanding bit and ignore rvalid in S_REQ.
- FSM states are S_REQ, S_WAIT, S_HOLD.
- S_REQ:
  - imem_req=1, imem_addr={F_PC[31:2],2'b00}.
  - gnt -> S_WAIT.
  - Else stay.
- S_WAIT, no rvalid: stay; imem_req=0.
- S_WAIT, rvalid && !stall ("deliver"):
  - D_Instr<=imem_rdata, D_PC<=F_PC, D_valid<=1.
  - F_PC<={npc_in[31:2],2'b00}.
  - Same cycle, back-to-back request: imem_req=1, imem_addr={npc_in[31:2],2'b00}.
  - gnt -> stay S_WAIT; else -> S_REQ.
- S_WAIT, rvalid && stall:
  - Capture imem_rdata in the hold buffer; -> S_HOLD.
  - F_PC unchanged, imem_req=0.
- S_HOLD:
  - imem_req=0.
  - On !stall, deliver from the hold buffer (same updates as above, no back-to-back request) and -> S_REQ.
- D register rules, every cycle outside reset:
  - stall=1: D_PC/D_Instr/D_valid hold, regardless of state.
  - stall=0 and no deliver: bubble, i.e. D_Instr<=NOP_INSTR, D_valid<=0, D_PC holds.
- Latency and throughput:
  - Zero-wait memory (gnt in the request cycle, rvalid the next cycle) gives one instruction per cycle after a 2-cycle start-up: first D_valid=1 at the 2nd posedge after reset release.
  - Each extra memory wait cycle inserts one bubble.
- F_PC changes only on deliver. npc_in is sampled only at deliver, when D holds the previous instruction, matching delayed-branch timing.
- On bubbles, D decodes as NOP, so the next-PC block selects PC+4. That value is not used, since no deliver occurs.
- Wrap-around: F_PC + 4 arithmetic belongs to the next-PC block. This block loads npc_in unmodified apart from bits [1:0]; 32'hFFFF_FFFC -> 0 is legal.
- Simultaneous stall and rvalid always goes to the hold buffer. It never drops data and never issues a second request while one is outstanding.

Decomposition:
- Shared cpu package holds:
  - Constant RESET_PC = 32'h0000_3000 and NOP encoding 32'h0.
  - FSM state encoding for S_REQ/S_WAIT/S_HOLD.
- One natural sub-module: fd_reg, the F/D pipeline register with enable (deliver) and bubble controls.
- Everything else stays in fetch_stage.

Test Plan:
- Reset, then zero-wait memory returning the word at each address (e.g. 0x3000 -> 0x24010001), npc_in=F_PC+4 -> D_PC sequence 0x3000, 0x3004, 0x3008 on consecutive cycles, D_valid=1 from cycle 2.
- Memory with 2 extra rvalid delay cycles -> exactly 2 bubbles (D_valid=0, D_Instr=0) between instructions; F_PC steps only on deliver.
- stall=1 for 3 cycles while rvalid arrives with 0x8C220004 -> D holds, imem_req=0, state S_HOLD; on release D_Instr=0x8C220004 with correct D_PC, no duplicate or lost instruction.
- npc_in=0x0000_3400 at deliver of the instruction at 0x3008 (taken branch) -> F_PC=0x3400, imem_addr=0x3400, D_PC=0x3008 that cycle.
- gnt held low for 4 cycles in S_REQ -> imem_req and imem_addr stable at F_PC; D bubbles if !stall, holds if stall.
- reset asserted in S_WAIT, rvalid arrives the cycle after release -> data ignored, outputs at reset values, first request to 0x3000.
